// File: rtl/us_timer_if.sv
// Control/status bundle for us_timer: time base, arm/abort requests, mode and
// duration in; busy, expiry pulse and remaining count out.
interface us_timer_if #(
    parameter int W = 16
);
    logic         us_tick;
    logic         start;
    logic         stop;
    logic         periodic;
    logic [W-1:0] dur_us;
    logic         busy;
    logic         done;
    logic [W-1:0] remain;

    modport master (
        output us_tick, start, stop, periodic, dur_us,
        input  busy, done, remain
    );

    modport slave (
        input  us_tick, start, stop, periodic, dur_us,
        output busy, done, remain
    );
endinterface

// File: rtl/us_timer.sv
// Microsecond down-counter with one-shot or auto-reload mode, counting an
// external 1 us tick; raises a single-cycle done pulse at each expiry.
module us_timer #(
    parameter int W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    us_timer_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state;
    logic [W-1:0] period;
    logic [W-1:0] remain_q;
    logic         periodic_q;
    logic         done_q;

    // Priority: stop, then start, then tick-driven decrement/expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period     <= '0;
            remain_q   <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state    <= IDLE;
                remain_q <= '0;
            end else if (bus.start) begin
                period     <= bus.dur_us;
                periodic_q <= bus.periodic;
                remain_q   <= bus.dur_us;
                if (bus.dur_us == '0) begin
                    // A zero duration expires at once without entering RUN.
                    state  <= IDLE;
                    done_q <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end else if (state == RUN && bus.us_tick) begin
                if (remain_q > W'(1)) begin
                    remain_q <= remain_q - W'(1);
                end else begin
                    done_q <= 1'b1;
                    if (periodic_q) begin
                        remain_q <= period;
                    end else begin
                        state    <= IDLE;
                        remain_q <= '0;
                    end
                end
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = done_q;
    assign bus.remain = remain_q;
endmodule

// File: doc/us_timer.md
US_TIMER -- requirements
Module: us_timer

Interface
REQ-001 Parameter W: default 16; width of the duration and remaining-count fields.
REQ-002 clk  input  1  system clock (50 MHz); all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 us_tick  input  1  1 us time base, one clk cycle high per microsecond; produced by the upstream tick generator.
REQ-005 start  input  1  single-cycle request to arm the timer.
REQ-006 stop  input  1  single-cycle abort request.
REQ-007 periodic  input  1  mode select, sampled only when start is accepted: 0 = one-shot, 1 = auto-reload.
REQ-008 dur_us  input  W  duration in microseconds, sampled only when start is accepted.
REQ-009 busy  output  1  high while the timer is in RUN.
REQ-010 done  output  1  one-cycle pulse at expiry.
REQ-011 remain  output  W  microseconds left in the current period; 0 when idle.

Function
REQ-012 Two states only: IDLE and RUN.
REQ-013 The block shall latch dur_us into an internal period register and into remain, and latch periodic, when start is accepted.
REQ-014 start accepted in IDLE with dur_us != 0: on the next edge, state = RUN, busy = 1, remain = dur_us.
REQ-015 start accepted in IDLE with dur_us == 0: done = 1 on the next edge; state stays IDLE; busy stays 0.
REQ-016 A us_tick coincident with an accepted start shall not be counted; counting begins on the first us_tick after RUN is entered.
REQ-017 In RUN, each cycle with us_tick = 1 and remain > 1 shall decrement remain by exactly 1; cycles with us_tick = 0 hold remain.
REQ-018 In RUN, us_tick = 1 with remain == 1, one-shot mode: next edge gives remain = 0, done = 1, state = IDLE, busy = 0.
REQ-019 In RUN, us_tick = 1 with remain == 1, periodic mode: next edge gives done = 1, remain = latched period, state stays RUN, busy stays 1.
REQ-020 start in RUN shall restart the timer: reload from the new dur_us and new periodic, with no done pulse; if the new dur_us == 0, behave as REQ-015 and go to IDLE.
REQ-021 stop in any state: next edge gives state = IDLE, busy = 0, remain = 0, done = 0.
REQ-022 Priority when events coincide: stop > start > us_tick expiry/decrement.
REQ-023 done shall be high for exactly one cycle per expiry and shall otherwise be 0.
REQ-024 Expiry timing: with duration N, done asserts on the edge following the N-th counted us_tick (elapsed time between N and N+1 us after start).
REQ-025 remain shall never wrap below 0; the maximum duration 2^W-1 shall be supported without overflow.

Reset
REQ-026 While rst_n = 0, asynchronously: state = IDLE, busy = 0, done = 0, remain = 0, period = 0, periodic latch = 0.
REQ-027 Reset asserted mid-RUN shall abort without a done pulse; after release the block shall stay IDLE until the next start.

Verification
REQ-028 us_tick every 50 clks; start with dur_us=3, periodic=0 -> busy=1 next cycle; remain steps 3,2,1; done one cycle after the 3rd tick; busy=0 afterwards.
REQ-029 dur_us=2, periodic=1 -> done every 2 ticks (100 clks), at least 3 times; remain reloads to 2; busy stays 1; then stop -> busy=0, remain=0, no done.
REQ-030 start with dur_us=0 -> done=1 for one cycle; busy never asserts.
REQ-031 start and us_tick in the same cycle with dur_us=1 -> that tick is not counted; done follows the next tick.
REQ-032 In RUN with remain=5, start with dur_us=10 -> remain=10, no done; stop and start in the same cycle -> IDLE.
REQ-033 rst_n low while remain=4 -> outputs 0 immediately; no done after release; us_tick pulses alone leave the block idle.
